mmio_bridge: RTL
================

// Module: mmio_bridge
// PURPOSE
//  Data-bus bridge between riscv_core's data_sram_* port and the DRAM/board peripherals.
//  Decodes each access to DRAM or to the MMIO page 0xFFFF_F000-0xFFFF_FFFF.
//  Owns the MMIO registers: 24 LEDs, 24 switches, an 8-digit 7-seg scanner and a prescaled timer.
//  Read data is combinational, because the single-cycle core samples rdata in the same cycle.
// PARAMETERS
//  DRAM_AW   16     DRAM word-address width; dram_addr = data_sram_addr[DRAM_AW+1:2]
//  SCAN_DIV  20000  clk cycles each 7-seg digit is held active (>=1)
//  TDIV_RST  1      reset value of the timer divider register
// PORTS
//  clk             in   1        system clock, rising edge
//  resetn          in   1        asynchronous, active-low reset
//  data_sram_en    in   1        core data access valid
//  data_sram_we    in   4        core byte write enables
//  data_sram_addr  in   32       core byte address
//  data_sram_wdata in   32       core write data
//  data_sram_rdata out  32       read data to core (combinational)
//  dram_we         out  4        DRAM byte write enables
//  dram_addr       out  DRAM_AW  DRAM word address
//  dram_wdata      out  32       DRAM write data (= data_sram_wdata)
//  dram_rdata      in   32       DRAM read data (combinational)
//  sw_i            in   24       raw board switches (asynchronous)
//  led_o           out  24       LED drive, 1 = on
//  dn_o            out  8        digit enables, active-low
//  seg_o           out  8        {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Decode: mmio = data_sram_en & (addr[31:12]==20'hFFFFF); dram_we = we & {4{en & ~mmio}}.
//  MMIO map (word offset in page); byte enables apply per byte; RO writes are ignored:
//   0x000 DIG  RW  8 hex nibbles, nibble k shown on digit k
//   0x020 TCNT RW  timer count        0x024 TDIV RW  timer divider
//   0x060 LED  RW  bits[23:0]; [31:24] read 0
//   0x070 SW   RO  {8'h0, sw_sync}
//   Any other MMIO offset reads 32'h0.
//  rdata = mmio ? mmio_reg(addr) : dram_rdata. The value is pre-write, i.e. the register value before this cycle's edge.
//  Reset values: DIG=0, LED=0, TCNT=0, TDIV=TDIV_RST, prescaler=0, scan idx=0, scan cnt=0, sw_sync=0.
//   At reset dn_o=8'hFE and seg_o=8'hC0 (digit 0 shows '0'). dp is always 1 (off).
//  Switch input: 2-flop synchronizer, so SW reflects sw_i 2 edges after it changes.
//  Timer: when TDIV==0 the prescaler and TCNT hold. Otherwise the prescaler counts 0..TDIV-1.
//   On the prescaler wrap, TCNT increments (mod 2^32; 0xFFFFFFFF -> 0).
//   A TCNT write in the same cycle as a tick: the write wins and the tick is lost.
//   A TDIV write clears the prescaler to 0.
//  Scanner: scan cnt counts 0..SCAN_DIV-1. On wrap, idx goes to (idx+1) mod 8.
//   dn_o = ~(8'b1 << idx); seg_o = hex decode of DIG[4*idx+:4].
//   Outputs come from registered idx, so there are no glitches between digits.
//  Async reset mid-operation forces all of the above reset values immediately.
//  data_sram_en=0: no register and no DRAM write occurs; rdata is still driven.
// CONFIGURATION
//  MMIO_TIMER_EN defined: timer present as described.
//  MMIO_TIMER_EN undefined: no timer logic is built; TCNT/TDIV read 0 and writes are ignored.
// STRUCTURE
//  Shared package/header mmio_defs: MMIO_BASE 20'hFFFFF, offsets OFF_DIG/OFF_TCNT/OFF_TDIV/OFF_LED/OFF_SW.
//  One sub-module: seg7_decode (combinational, 4-bit hex in -> 7 active-low segments).
//  Patterns: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
// TESTING
//  1 Write 0x0000_1234, we=4'hF, addr 0x0000_0010 -> dram_we=F, dram_addr=4, led_o unchanged.
//    Then read the same address -> rdata=dram_rdata.
//  2 Write 0x00AB_CDEF to 0xFFFF_F060 with we=4'b0001 -> led_o=24'h0000EF; dram_we=0.
//    Then read 0xFFFF_F060 -> 0x0000_00EF.
//  3 sw_i=24'h5A5A5A at edge 0 -> SW reads 0 after 1 edge and 0x005A5A5A after 2 edges.
//    Read 0xFFFF_F0FC -> 0.
//  4 TDIV=3 -> TCNT increments every 3 clk. Preload TCNT=0xFFFF_FFFF -> wraps to 0.
//    Write TCNT=7 on a tick cycle -> TCNT=7.
//    TDIV=0 -> TCNT frozen. Without MMIO_TIMER_EN, 0xFFFF_F020 reads 0.
//  5 SCAN_DIV=2, DIG=0x7654_3210 -> dn_o sequence FE,FD,FB..7F, each held 2 clk.
//    seg_o sequence C0,F9,A4,B0,99,92,82,F8; then wraps to FE.
//  6 Assert resetn=0 mid-scan with LED=0xFFFFFF and TCNT=9 -> immediately led_o=0, TCNT=0, dn_o=FE, seg_o=C0.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// rtl/mmio_bridge_pkg.sv - shared MMIO page constants, register select type and byte-merge helper
package mmio_defs;

  localparam logic [19:0] MMIO_BASE = 20'hFFFFF;

  localparam logic [11:0] OFF_DIG  = 12'h000;
  localparam logic [11:0] OFF_TCNT = 12'h020;
  localparam logic [11:0] OFF_TDIV = 12'h024;
  localparam logic [11:0] OFF_LED  = 12'h060;
  localparam logic [11:0] OFF_SW   = 12'h070;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DIG,
    SEL_TCNT,
    SEL_TDIV,
    SEL_LED,
    SEL_SW
  } reg_sel_e;

  // Word offset inside the page (byte offset bits [11:2]) to register select
  function automatic reg_sel_e decode_sel(input logic [9:0] word_off);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word_off == OFF_DIG[11:2])  sel = SEL_DIG;
    if (word_off == OFF_TCNT[11:2]) sel = SEL_TCNT;
    if (word_off == OFF_TDIV[11:2]) sel = SEL_TDIV;
    if (word_off == OFF_LED[11:2])  sel = SEL_LED;
    if (word_off == OFF_SW[11:2])   sel = SEL_SW;
    return sel;
  endfunction

  // Replace only the bytes whose enable is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_bridge_seg7_decode.sv
// rtl/mmio_bridge_seg7_decode.sv - hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}
module seg7_decode (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Pure lookup; dp is handled by the caller
  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - core data bus bridge to DRAM and MMIO page (LED/SW/7-seg/timer); timer built only with MMIO_TIMER_EN
module mmio_bridge
  import mmio_defs::*;
#(
  parameter int          DRAM_AW  = 16,
  parameter int          SCAN_DIV = 20000,
  parameter logic [31:0] TDIV_RST = 32'd1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               data_sram_en,
  input  logic [3:0]         data_sram_we,
  input  logic [31:0]        data_sram_addr,
  input  logic [31:0]        data_sram_wdata,
  output logic [31:0]        data_sram_rdata,
  output logic [3:0]         dram_we,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw_i,
  output logic [23:0]        led_o,
  output logic [7:0]         dn_o,
  output logic [7:0]         seg_o
);

  localparam int SCAN_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_DIV - 1);

  logic               w_mmio;
  reg_sel_e           w_sel;
  logic               w_wr;
  logic               w_unused_lsb;
  logic [31:0]        w_reg_rdata;
  logic [31:0]        w_tcnt_rd;
  logic [31:0]        w_tdiv_rd;
  logic [3:0]         w_nibble;
  logic [6:0]         w_seg;

  logic [31:0]        r_dig;
  logic [23:0]        r_led;
  logic [23:0]        r_sw_meta;
  logic [23:0]        r_sw_sync;
  logic [SCAN_CW-1:0] r_scan_cnt;
  logic [2:0]         r_scan_idx;

  assign w_mmio       = data_sram_en & (data_sram_addr[31:12] == MMIO_BASE);
  assign w_sel        = decode_sel(data_sram_addr[11:2]);
  assign w_wr         = w_mmio & (|data_sram_we);
  // Byte lane within the word never selects a register
  assign w_unused_lsb = ^data_sram_addr[1:0];

  assign dram_we    = data_sram_we & {4{data_sram_en & ~w_mmio}};
  assign dram_addr  = data_sram_addr[DRAM_AW+1:2];
  assign dram_wdata = data_sram_wdata;

  // DIG and LED registers with per-byte write enables
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dig <= '0;
      r_led <= '0;
    end else begin
      if (w_wr && (w_sel == SEL_DIG)) begin
        r_dig <= byte_merge(r_dig, data_sram_wdata, data_sram_we);
      end
      if (w_wr && (w_sel == SEL_LED)) begin
        for (int b = 0; b < 3; b++) begin
          if (data_sram_we[b]) r_led[8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] r_tcnt;
  logic [31:0] r_tdiv;
  logic [31:0] r_presc;
  logic        w_tick;
  logic        w_wr_tcnt;
  logic        w_wr_tdiv;

  assign w_tick    = (r_tdiv != 32'd0) && (r_presc == r_tdiv - 32'd1);
  assign w_wr_tcnt = w_wr && (w_sel == SEL_TCNT);
  assign w_wr_tdiv = w_wr && (w_sel == SEL_TDIV);

  // Prescaled timer; a software TCNT write overrides a coincident tick
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tcnt  <= '0;
      r_tdiv  <= TDIV_RST;
      r_presc <= '0;
    end else begin
      if (w_wr_tdiv) begin
        r_tdiv  <= byte_merge(r_tdiv, data_sram_wdata, data_sram_we);
        r_presc <= '0;
      end else if (r_tdiv != 32'd0) begin
        r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
      end
      if (w_wr_tcnt) begin
        r_tcnt <= byte_merge(r_tcnt, data_sram_wdata, data_sram_we);
      end else if (w_tick) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
    end
  end

  assign w_tcnt_rd = r_tcnt;
  assign w_tdiv_rd = r_tdiv;
`else
  assign w_tcnt_rd = '0;
  assign w_tdiv_rd = '0;
`endif

  // Digit scanner: hold each digit SCAN_DIV cycles, then advance mod 8
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_nibble = r_dig[{r_scan_idx, 2'b00} +: 4];

  seg7_decode u_seg7 (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  assign dn_o  = ~(8'b1 << r_scan_idx);
  assign seg_o = {1'b1, w_seg};
  assign led_o = r_led;

  // Combinational read path; values are the pre-edge register contents
  always_comb begin
    w_reg_rdata = '0;
    case (w_sel)
      SEL_DIG:  w_reg_rdata = r_dig;
      SEL_TCNT: w_reg_rdata = w_tcnt_rd;
      SEL_TDIV: w_reg_rdata = w_tdiv_rd;
      SEL_LED:  w_reg_rdata = {8'h0, r_led};
      SEL_SW:   w_reg_rdata = {8'h0, r_sw_sync};
      default:  w_reg_rdata = '0;
    endcase
  end

  assign data_sram_rdata = w_mmio ? w_reg_rdata : dram_rdata;

endmodule
